regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-ported register file; successor to the single-write, two-read 32x32 MIPS register file in the processor datapath.
- Adds the following:
  - configurable width, depth and read-port count;
  - two write ports with fixed priority;
  - optional write-to-read bypass;
  - synchronous clear;
  - a pending-write scoreboard so the pipelined core can stall on registers awaiting multi-cycle results (loads, multiply/divide).

Parameters:
- WIDTH, 32, data bits per register
- AW, 5, address bits; depth = 2**AW
- NR, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ra  in  NR*AW  read addresses; port i = ra[i*AW +: AW]
- rd  out  NR*WIDTH  read data; port i = rd[i*WIDTH +: WIDTH]
- rbusy  out  NR  per-read-port pending flag
- we3  in  1  write enable, port A (high priority)
- wa3  in  AW  write address, port A
- wd3  in  WIDTH  write data, port A
- we4  in  1  write enable, port B (low priority)
- wa4  in  AW  write address, port B
- wd4  in  WIDTH  write data, port B
- pset  in  1  mark register pending
- pwa  in  AW  register to mark pending
- pcnt  out  AW+1  number of registers currently pending

Behaviour:
- Reset:
  - At posedge clk with reset=1, all registers are set to 0 and all pending bits are cleared. pcnt=0 the following cycle.
  - Reset overrides any simultaneous write or pset.
  - Outputs rd and rbusy are combinational from state and ra, so both are 0 after reset.
- Write:
  - At posedge, if we3, then rf[wa3] <= wd3. If we4, then rf[wa4] <= wd4.
  - we3 && we4 && wa3==wa4: port A data is stored and port B is dropped.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0.
  - pset to address 0 is ignored, so address 0 is never pending.
- Read:
  - Combinational, zero latency.
  - BYPASS=0: rd returns the stored value; a write is visible the cycle after its edge.
  - BYPASS=1: if ra(i) matches an active write this cycle, rd(i) returns that write's data, with port A taking precedence over port B. The zero-register rule still applies.
- Scoreboard, one pending bit per register:
  - Set at posedge when pset is high, for register pwa.
  - Cleared at posedge by any write (we3 or we4) to that register.
  - pset and a write to the same address in the same cycle: the bit ends set, because the new producer wins.
  - pset to an already-pending register: no change.
- rbusy(i):
  - Equals pend[ra(i)].
  - BYPASS=1: forced to 0 when a write to ra(i) occurs this cycle.
  - Always 0 for address 0 when ZERO_REG=1.
- pcnt:
  - Registered population count of the pending bits; updated at the same edge as the bits.
  - Each cycle it changes by +1, -1, -2 or 0 (the latter including a set and a clear in the same cycle). It never wraps; its maximum is 2**AW - ZERO_REG.
- No internal state machine beyond the register, pending and count state. No X propagation: no read path depends on uninitialised state after reset.

Test Plan:
- Reset, write, read: apply reset, then read every address on all NR ports -> 0. Write 0xDEADBEEF to r5 via port A, read r5 next cycle -> 0xDEADBEEF.
- Zero register: we3 writes 0x12345678 to r0 and pset to r0 -> rd=0, rbusy=0, pcnt=0. Repeat with ZERO_REG=0 -> r0 reads 0x12345678.
- Write conflict: we3 wd3=0xAAAA0000 and we4 wd4=0x0000BBBB, both to r7 -> r7=0xAAAA0000. Distinct addresses r7/r8 -> both stored.
- Bypass: BYPASS=1 with ra0=r9 while writing 0xCAFEF00D to r9 -> rd0=0xCAFEF00D in the same cycle. BYPASS=0 -> old value that cycle, new value next cycle.
- Scoreboard: pset r3, then pset r4 -> pcnt=2, rbusy high for ra=r3. we4 to r3 -> pcnt=1. Simultaneous pset r4 and we3 to r4 -> r4 stays pending, pcnt=1.
- Reset mid-operation: r3 pending and r10 holding 0x55 -> assert reset together with we3 to r11 -> all registers 0, pcnt=0, r11=0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-ported register file: read ports, two write
// ports, the pending-mark port and the pending count.
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NR    = 2
);
  logic [NR*AW-1:0]    ra;
  logic [NR*WIDTH-1:0] rd;
  logic [NR-1:0]       rbusy;
  logic                we3;
  logic [AW-1:0]       wa3;
  logic [WIDTH-1:0]    wd3;
  logic                we4;
  logic [AW-1:0]       wa4;
  logic [WIDTH-1:0]    wd4;
  logic                pset;
  logic [AW-1:0]       pwa;
  logic [AW:0]         pcnt;

  modport master (
    output ra, we3, wa3, wd3, we4, wa4, wd4, pset, pwa,
    input  rd, rbusy, pcnt
  );

  modport slave (
    input  ra, we3, wa3, wd3, we4, wa4, wd4, pset, pwa,
    output rd, rbusy, pcnt
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file: NR combinational read ports, two prioritised
// write ports (A over B), optional write-to-read bypass, synchronous clear,
// and a per-register pending scoreboard with a registered pending count.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0]    rf [DEPTH];
  logic [DEPTH-1:0]    pend;
  logic [DEPTH-1:0]    pend_nxt;
  logic [AW:0]         pcnt_q;
  logic                w3_en;
  logic                w4_en;
  logic                ps_en;
  logic [NR*WIDTH-1:0] rd_c;
  logic [NR-1:0]       busy_c;

  // Address 0 is a constant-zero register only when ZERO_REG is set.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + (AW + 1)'(v[i]);
    return c;
  endfunction

  // Writes and pending marks aimed at the zero register are discarded here,
  // so nothing downstream needs to special-case address 0 again.
  assign w3_en = bus.we3 && !is_zero(bus.wa3);
  assign w4_en = bus.we4 && !is_zero(bus.wa4);
  assign ps_en = bus.pset && !is_zero(bus.pwa);

  // Next pending vector: writes retire producers, a new pset wins over a
  // write to the same register because the new producer is still in flight.
  always_comb begin
    pend_nxt = pend;
    if (w4_en) pend_nxt[bus.wa4] = 1'b0;
    if (w3_en) pend_nxt[bus.wa3] = 1'b0;
    if (ps_en) pend_nxt[bus.pwa] = 1'b1;
  end

  // Register storage; port A is written last so it wins an address clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      if (w4_en) rf[bus.wa4] <= bus.wd4;
      if (w3_en) rf[bus.wa3] <= bus.wd3;
    end
  end

  // Pending bits and their population count advance together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend   <= '0;
      pcnt_q <= '0;
    end else begin
      pend   <= pend_nxt;
      pcnt_q <= popcount(pend_nxt);
    end
  end

  // Read ports: stored value, optionally overridden by a same-cycle write
  // (A over B); a register being written is no longer reported busy.
  always_comb begin
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             b;
    rd_c   = '0;
    busy_c = '0;
    for (int i = 0; i < NR; i++) begin
      a = bus.ra[i*AW +: AW];
      d = rf[a];
      b = pend[a];
      if (BYPASS != 0) begin
        if (w4_en && (bus.wa4 == a)) begin
          d = bus.wd4;
          b = 1'b0;
        end
        if (w3_en && (bus.wa3 == a)) begin
          d = bus.wd3;
          b = 1'b0;
        end
      end
      if (is_zero(a)) begin
        d = '0;
        b = 1'b0;
      end
      rd_c[i*WIDTH +: WIDTH] = d;
      busy_c[i]              = b;
    end
  end

  assign bus.rd    = rd_c;
  assign bus.rbusy = busy_c;
  assign bus.pcnt  = pcnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share one stimulus stream, one with
// the zero register and bypass enabled, one with both disabled.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic        we3, we4, pset;
  logic [4:0]  wa3, wa4, pwa, ra0, ra1;
  logic [31:0] wd3, wd4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(32), .AW(5), .NR(2)) ifa ();
  regfile_mp_if #(.WIDTH(32), .AW(5), .NR(2)) ifb ();

  assign ifa.ra = {ra1, ra0};  assign ifb.ra = {ra1, ra0};
  assign ifa.we3 = we3;        assign ifb.we3 = we3;
  assign ifa.wa3 = wa3;        assign ifb.wa3 = wa3;
  assign ifa.wd3 = wd3;        assign ifb.wd3 = wd3;
  assign ifa.we4 = we4;        assign ifb.we4 = we4;
  assign ifa.wa4 = wa4;        assign ifb.wa4 = wa4;
  assign ifa.wd4 = wd4;        assign ifb.wd4 = wd4;
  assign ifa.pset = pset;      assign ifb.pset = pset;
  assign ifa.pwa = pwa;        assign ifb.pwa = pwa;

  regfile_mp #(.WIDTH(32), .AW(5), .NR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  regfile_mp #(.WIDTH(32), .AW(5), .NR(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    string       name;
    logic        rst, we3, we4, pset, chk;
    logic [4:0]  wa3, wa4, pwa, ra0, ra1;
    logic [31:0] wd3, wd4;
    logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
    logic [1:0]  a_bz, b_bz;
    logic [5:0]  a_pc, b_pc;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] a_pc;
    logic [5:0] b_pc;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[$];

  function automatic vec_t mk(
    input string n,
    input logic [31:0] rst, we3_i, wa3_i, wd3_i, we4_i, wa4_i, wd4_i,
    input logic [31:0] pset_i, pwa_i, ra0_i, ra1_i, chk,
    input logic [31:0] ard0, ard1, abz, brd0, brd1, bbz, apc, bpc);
    vec_t v;
    v.name = n;       v.rst = rst[0];
    v.we3 = we3_i[0]; v.wa3 = wa3_i[4:0]; v.wd3 = wd3_i;
    v.we4 = we4_i[0]; v.wa4 = wa4_i[4:0]; v.wd4 = wd4_i;
    v.pset = pset_i[0]; v.pwa = pwa_i[4:0];
    v.ra0 = ra0_i[4:0]; v.ra1 = ra1_i[4:0]; v.chk = chk[0];
    v.a_rd0 = ard0; v.a_rd1 = ard1; v.a_bz = abz[1:0];
    v.b_rd0 = brd0; v.b_rd1 = brd1; v.b_bz = bbz[1:0];
    v.a_pc = apc[5:0]; v.b_pc = bpc[5:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check combinational reads before
  // the rising edge, then check the registered count from the scoreboard.
  task automatic apply(input vec_t v);
    sb_t e;
    @(negedge clk);
    reset = v.rst;
    we3 = v.we3;  wa3 = v.wa3;  wd3 = v.wd3;
    we4 = v.we4;  wa4 = v.wa4;  wd4 = v.wd4;
    pset = v.pset; pwa = v.pwa;
    ra0 = v.ra0;  ra1 = v.ra1;
    sbq.push_back('{name: v.name, a_pc: v.a_pc, b_pc: v.b_pc});
    #1;
    if (v.chk) begin
      chk({v.name, " A.rd0"},   ifa.rd[31:0],      v.a_rd0);
      chk({v.name, " A.rd1"},   ifa.rd[63:32],     v.a_rd1);
      chk({v.name, " A.rbusy"}, 32'(ifa.rbusy),    32'(v.a_bz));
      chk({v.name, " B.rd0"},   ifb.rd[31:0],      v.b_rd0);
      chk({v.name, " B.rd1"},   ifb.rd[63:32],     v.b_rd1);
      chk({v.name, " B.rbusy"}, 32'(ifb.rbusy),    32'(v.b_bz));
    end
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", v.name);
    end else begin
      e = sbq.pop_front();
      chk({e.name, " A.pcnt"}, 32'(ifa.pcnt), 32'(e.a_pc));
      chk({e.name, " B.pcnt"}, 32'(ifb.pcnt), 32'(e.b_pc));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; we3 = 1'b0; we4 = 1'b0; pset = 1'b0;
    wa3 = '0; wa4 = '0; pwa = '0; ra0 = '0; ra1 = '0; wd3 = '0; wd4 = '0;

    // Directed table; state carries from one row to the next.
    //              name         rst we3 wa3 wd3            we4 wa4 wd4          ps pwa ra0 ra1 chk  A.rd0         A.rd1         Abz B.rd0         B.rd1         Bbz Apc Bpc
    tbl.push_back(mk("wr_r5",     0, 1,  5, 32'hDEADBEEF,  0,  0, 0,            0,  0,  5,  1, 1,   32'hDEADBEEF, 0,            0,  0,            0,            0,  0,  0));
    tbl.push_back(mk("rd_r5",     0, 0,  0, 0,             0,  0, 0,            0,  0,  5,  5, 1,   32'hDEADBEEF, 32'hDEADBEEF, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0,  0,  0));
    tbl.push_back(mk("zero_wr",   0, 1,  0, 32'h12345678,  0,  0, 0,            1,  0,  0,  5, 1,   0,            32'hDEADBEEF, 0,  0,            32'hDEADBEEF, 0,  0,  1));
    tbl.push_back(mk("zero_rd",   0, 0,  0, 0,             0,  0, 0,            0,  0,  0,  0, 1,   0,            0,            0,  32'h12345678, 32'h12345678, 3,  0,  1));
    tbl.push_back(mk("conflict",  0, 1,  7, 32'hAAAA0000,  1,  7, 32'h0000BBBB, 0,  0,  7,  0, 1,   32'hAAAA0000, 0,            0,  0,            32'h12345678, 2,  0,  1));
    tbl.push_back(mk("conf_rd",   0, 0,  0, 0,             0,  0, 0,            0,  0,  7,  7, 1,   32'hAAAA0000, 32'hAAAA0000, 0,  32'hAAAA0000, 32'hAAAA0000, 0,  0,  1));
    tbl.push_back(mk("dist_wr",   0, 1,  7, 32'h77770007,  1,  8, 32'h88880008, 0,  0,  7,  8, 1,   32'h77770007, 32'h88880008, 0,  32'hAAAA0000, 0,            0,  0,  1));
    tbl.push_back(mk("dist_rd",   0, 0,  0, 0,             0,  0, 0,            0,  0,  7,  8, 1,   32'h77770007, 32'h88880008, 0,  32'h77770007, 32'h88880008, 0,  0,  1));
    tbl.push_back(mk("byp_wr",    0, 1,  9, 32'hCAFEF00D,  0,  0, 0,            0,  0,  9,  9, 1,   32'hCAFEF00D, 32'hCAFEF00D, 0,  0,            0,            0,  0,  1));
    tbl.push_back(mk("byp_rd",    0, 0,  0, 0,             0,  0, 0,            0,  0,  9,  0, 1,   32'hCAFEF00D, 0,            0,  32'hCAFEF00D, 32'h12345678, 2,  0,  1));
    tbl.push_back(mk("byp_b",     0, 0,  0, 0,             1, 12, 32'h0B0B0B0B, 0,  0, 12, 12, 1,   32'h0B0B0B0B, 32'h0B0B0B0B, 0,  0,            0,            0,  0,  1));
    tbl.push_back(mk("pset_r3",   0, 0,  0, 0,             0,  0, 0,            1,  3,  3,  4, 1,   0,            0,            0,  0,            0,            0,  1,  2));
    tbl.push_back(mk("pset_r4",   0, 0,  0, 0,             0,  0, 0,            1,  4,  3,  4, 1,   0,            0,            1,  0,            0,            1,  2,  3));
    tbl.push_back(mk("pset_dup",  0, 0,  0, 0,             0,  0, 0,            1,  3,  3,  4, 1,   0,            0,            3,  0,            0,            3,  2,  3));
    tbl.push_back(mk("clr_r3",    0, 0,  0, 0,             1,  3, 32'h33,       0,  0,  3,  4, 1,   32'h33,       0,            2,  0,            0,            3,  1,  2));
    tbl.push_back(mk("set_wr_r4", 0, 1,  4, 32'h44,        0,  0, 0,            1,  4,  3,  4, 1,   32'h33,       32'h44,       0,  32'h33,       0,            2,  1,  2));
    tbl.push_back(mk("chk_r4",    0, 0,  0, 0,             0,  0, 0,            0,  0,  4,  3, 1,   32'h44,       32'h33,       1,  32'h44,       32'h33,       1,  1,  2));
    tbl.push_back(mk("clr_two",   0, 1,  4, 32'h4040,      1,  0, 32'h5050,     0,  0,  4,  0, 1,   32'h4040,     0,            0,  32'h44,       32'h12345678, 3,  0,  0));
    tbl.push_back(mk("after_clr", 0, 0,  0, 0,             0,  0, 0,            0,  0,  0,  4, 1,   0,            32'h4040,     0,  32'h5050,     32'h4040,     0,  0,  0));
    tbl.push_back(mk("pset_r3b",  0, 1, 10, 32'h55,        0,  0, 0,            1,  3, 10,  3, 1,   32'h55,       32'h33,       0,  0,            32'h33,       0,  1,  1));
    tbl.push_back(mk("set_clr",   0, 0,  0, 0,             1,  3, 32'h3333,     1, 13,  3, 13, 1,   32'h3333,     0,            0,  32'h33,       0,            1,  1,  1));
    tbl.push_back(mk("pset_r3c",  0, 0,  0, 0,             0,  0, 0,            1,  3, 10, 13, 1,   32'h55,       0,            2,  32'h55,       0,            2,  2,  2));
    tbl.push_back(mk("rst_mid",   1, 1, 11, 32'hBADBAD,    0,  0, 0,            1,  5,  3, 10, 1,   32'h3333,     32'h55,       1,  32'h3333,     32'h55,       1,  0,  0));
    tbl.push_back(mk("post_rst",  0, 0,  0, 0,             0,  0, 0,            0,  0, 11, 10, 1,   0,            0,            0,  0,            0,            0,  0,  0));
    tbl.push_back(mk("post_rst2", 0, 0,  0, 0,             0,  0, 0,            0,  0,  3, 13, 1,   0,            0,            0,  0,            0,            0,  0,  0));

    // Reset that must override a simultaneous write and pset.
    apply(mk("reset0", 1, 1, 11, 32'h99, 0, 0, 0, 1, 2, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 0));

    // Every address on both ports reads zero after reset.
    for (int a = 0; a < 32; a++)
      apply(mk($sformatf("rst_rd%0d", a), 0, 0, 0, 0, 0, 0, 0, 0, 0,
               32'(a), 32'(31 - a), 1, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Mark every register pending: count saturates at depth minus the
    // zero register and must not wrap.
    for (int a = 0; a < 32; a++)
      apply(mk($sformatf("fill%0d", a), 0, 0, 0, 0, 0, 0, 0, 1, 32'(a),
               32'(a), 0, 1, 0, 0, 0, 0, 0, (a >= 1) ? 2 : 0,
               32'(a), 32'(a + 1)));
    apply(mk("fill_dup", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1,
             0, 0, 1, 0, 0, 3, 31, 32));
    apply(mk("final_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,
             0, 0, 1, 0, 0, 3, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
